ofmap_assembler: RTL and testbench
==================================

OFMAP_ASSEMBLER -- requirements
Module: ofmap_assembler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the bit width of one feature-map pixel.
REQ-002 SHALL have parameter H, default 32, the input image height.
REQ-003 SHALL have parameter W, default 32, the input image width.
REQ-004 SHALL have parameter F, default 5, the filter size; derived OH = H-F+1, OW = W-F+1, HALF = OW/2, with OW even.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit, a single-cycle request to begin a new frame.
REQ-008 SHALL have port in_valid, input, 1 bit, meaning conv-unit half-row results are present.
REQ-009 SHALL have port in_data, input, HALF*DATA_WIDTH bits; pixel p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-011 SHALL have port rowNumber, output, 11 bits, the output row currently being requested.
REQ-012 SHALL have port column, output, 11 bits, the half-row select: 0 selects pixels 0..HALF-1, 1 selects pixels HALF..OW-1.
REQ-013 SHALL have port outImage, output, OH*OW*DATA_WIDTH bits, the assembled map; pixel (r,c) occupies [(r*OW+c)*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port frame_valid, output, 1 bit, high while a complete frame is held in outImage.
REQ-015 SHALL have port frame_ack, input, 1 bit, the consumer's release of the held frame.
REQ-016 SHALL have port busy, output, 1 bit, high while in COLLECT.

Function
REQ-017 SHALL implement states IDLE, COLLECT and DONE.
REQ-018 IDLE: on start=1, SHALL go to COLLECT with rowNumber=0 and column=0; otherwise SHALL stay in IDLE.
REQ-019 SHALL drive in_ready=1 only in COLLECT; an accept occurs on any edge where in_valid and in_ready are both 1.
REQ-020 On accept, SHALL write in_data into outImage pixels rowNumber*OW + column*HALF + p, for p = 0..HALF-1, on that same edge; all other pixels are unchanged.
REQ-021 On accept with column=0, SHALL set column to 1 with rowNumber unchanged.
REQ-022 On accept with column=1 and rowNumber<OH-1, SHALL set column to 0 and increment rowNumber.
REQ-023 On accept at rowNumber=OH-1 and column=1, SHALL go to DONE, with frame_valid=1 from the next cycle.
REQ-024 DONE: SHALL hold frame_valid=1 with outImage, rowNumber and column stable until frame_ack=1, then go to IDLE and clear frame_valid on that edge.
REQ-025 In IDLE, SHALL return rowNumber and column to 0.
REQ-026 SHALL ignore start in COLLECT and DONE, with no restart and no counter change.
REQ-027 SHALL ignore frame_ack outside DONE.
REQ-028 SHALL ignore in_valid outside COLLECT, with no write and no counter change.
REQ-029 When in_valid is held high, SHALL accept one half-row per cycle; the minimum frame time is 2*OH cycles from the COLLECT entry edge.
REQ-030 When in_valid stalls mid-frame, SHALL hold all counters and outImage with no timeout.
REQ-031 SHALL NOT clear outImage on start; each new frame overwrites every pixel.
REQ-032 busy SHALL equal 1 exactly when the state is COLLECT.

Reset
REQ-033 While reset=1, SHALL asynchronously force state=IDLE, rowNumber=0, column=0, outImage=0, frame_valid=0, busy=0 and in_ready=0.
REQ-034 A reset asserted mid-COLLECT or in DONE SHALL abandon the frame, and no partial frame_valid is produced.
REQ-035 After reset deasserts, SHALL take no action until the next start.

Verification
REQ-036 Reset then start, then in_valid=1 for 56 cycles with in_data pixel p = {row,col,p} pattern -> frame_valid rises the cycle after the 56th accept, and outImage(r,c) equals the pattern for every r,c in 0..27.
REQ-037 Within a frame, drop in_valid for 3 cycles after the accept at row 5, column 0 -> rowNumber=5 and column=1 are held, nothing is written, and the frame completes correctly at 59 cycles.
REQ-038 Pulse start during COLLECT and during DONE -> no counter or state change, and frame_valid remains until frame_ack.
REQ-039 Assert reset asynchronously at row 13, column 1 -> all outputs reach their reset values before the next clk edge, and frame_valid never asserts.
REQ-040 Complete two back-to-back frames with frame_ack one cycle after frame_valid -> the second frame's outImage fully replaces the first, and in_data presented in IDLE or DONE is not written.

Source files
------------

// File: rtl/ofmap_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ofmap_assembler
// Purpose  : Collects half-row conv results (HALF pixels per beat) into a
//            complete OH x OW output feature map and holds it until the
//            consumer acknowledges it.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-high reset
//            start        - one-cycle request to begin a frame (IDLE only)
//            in_valid     - half-row data present on in_data
//            in_data      - HALF pixels, pixel p at [p*DATA_WIDTH +: DATA_WIDTH]
//            in_ready     - block accepts in_data this cycle (COLLECT)
//            rowNumber    - output row currently requested
//            column       - half-row select (0: pixels 0..HALF-1, 1: rest)
//            outImage     - assembled map, pixel (r,c) at (r*OW+c)*DATA_WIDTH
//            frame_valid  - a complete frame is held (DONE)
//            frame_ack    - consumer releases the held frame
//            busy         - high while collecting
// Revision : 1.0 - initial release
// ============================================================================
module ofmap_assembler #(
  parameter int DATA_WIDTH = 16,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          start,
  input  logic                                          in_valid,
  input  logic [((W-F+1)/2)*DATA_WIDTH-1:0]             in_data,
  output logic                                          in_ready,
  output logic [10:0]                                   rowNumber,
  output logic [10:0]                                   column,
  output logic [(H-F+1)*(W-F+1)*DATA_WIDTH-1:0]         outImage,
  output logic                                          frame_valid,
  input  logic                                          frame_ack,
  output logic                                          busy
);

  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int HALF = OW / 2;
  localparam int IMG_BITS  = OH * OW * DATA_WIDTH;
  localparam int BEAT_BITS = HALF * DATA_WIDTH;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [10:0]         row_q, row_d;
  logic                col_q, col_d;
  logic [IMG_BITS-1:0] img_q, img_d;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    img_d   = img_q;
    case (state_q)
      S_IDLE: begin
        row_d = 11'd0;
        col_d = 1'b0;
        if (start) begin
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (in_valid) begin
          // Each (row, half) slot is a fixed slice; only the addressed one
          // is loaded, so every other pixel keeps its value.
          for (int r = 0; r < OH; r++) begin
            for (int h = 0; h < 2; h++) begin
              if (row_q == 11'(r) && col_q == 1'(h)) begin
                img_d[(r*OW + h*HALF)*DATA_WIDTH +: BEAT_BITS] = in_data;
              end
            end
          end
          if (!col_q) begin
            col_d = 1'b1;
          end else if (row_q == 11'(OH-1)) begin
            // Last half-row: counters stay at the final position in DONE.
            state_d = S_DONE;
          end else begin
            col_d = 1'b0;
            row_d = row_q + 11'd1;
          end
        end
      end
      S_DONE: begin
        if (frame_ack) begin
          state_d = S_IDLE;
          row_d   = 11'd0;
          col_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        row_d   = 11'd0;
        col_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= 11'd0;
      col_q   <= 1'b0;
      img_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      img_q   <= img_d;
    end
  end

  assign in_ready    = (state_q == S_COLLECT);
  assign busy        = (state_q == S_COLLECT);
  assign frame_valid = (state_q == S_DONE);
  assign rowNumber   = row_q;
  assign column      = {10'd0, col_q};
  assign outImage    = img_q;

endmodule
`default_nettype wire

// File: tb/tb_ofmap_assembler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ofmap_assembler
// Purpose  : Self-checking bench for ofmap_assembler. A frame-level reference
//            model (phase + count of accepted half-rows + expected image)
//            predicts every output after each clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofmap_assembler;

  localparam int DW   = 16;
  localparam int H    = 32;
  localparam int W    = 32;
  localparam int F    = 5;
  localparam int OH   = H - F + 1;
  localparam int OW   = W - F + 1;
  localparam int HALF = OW / 2;
  localparam int IMG  = OH * OW * DW;
  localparam int BEAT = HALF * DW;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            in_valid;
  logic [BEAT-1:0] in_data;
  logic            frame_ack;
  logic            in_ready;
  logic [10:0]     rowNumber;
  logic [10:0]     column;
  logic [IMG-1:0]  outImage;
  logic            frame_valid;
  logic            busy;

  ofmap_assembler #(.DATA_WIDTH(DW), .H(H), .W(W), .F(F)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rowNumber  (rowNumber),
    .column     (column),
    .outImage   (outImage),
    .frame_valid(frame_valid),
    .frame_ack  (frame_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = idle, 1 = collecting, 2 = frame held.
  // m_k counts accepted half-rows of the current frame.
  int             m_phase;
  int             m_k;
  logic [IMG-1:0] exp_img;
  int             n_checks = 0;
  int             n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_k     = 0;
    exp_img = '0;
  endtask

  function automatic int diff_pixels();
    int n = 0;
    for (int i = 0; i < OH*OW; i++)
      if (outImage[i*DW +: DW] !== exp_img[i*DW +: DW]) n++;
    return n;
  endfunction

  function automatic logic [BEAT-1:0] rnd_data();
    logic [BEAT-1:0] d;
    for (int i = 0; i < BEAT; i += 32) d[i +: 32] = 32'($urandom);
    return d;
  endfunction

  // Pixel p of half h of row r carries {row, half, p}.
  function automatic logic [BEAT-1:0] pat_data(input int acc);
    logic [BEAT-1:0] d;
    for (int p = 0; p < HALF; p++) d[p*DW +: DW] = 16'(((acc/2) << 9) | ((acc%2) << 8) | p);
    return d;
  endfunction

  task automatic check_outputs();
    check("in_ready",    in_ready,    m_phase == 1);
    check("busy",        busy,        m_phase == 1);
    check("frame_valid", frame_valid, m_phase == 2);
    check("rowNumber",   rowNumber,   m_k / 2);
    check("column",      column,      m_k % 2);
    check("img_diff",    diff_pixels(), 0);
  endtask

  // Advance one clock: capture the driven inputs, let the edge happen,
  // apply the frame-level rules to the model, then compare.
  task automatic tick();
    bit              r, s, v, a;
    logic [BEAT-1:0] d;
    r = reset; s = start; v = in_valid; a = frame_ack; d = in_data;
    @(posedge clk);
    if (r) model_reset();
    else begin
      case (m_phase)
        0: if (s) begin m_phase = 1; m_k = 0; end
        1: if (v) begin
             exp_img[((m_k/2)*OW + (m_k%2)*HALF)*DW +: BEAT] = d;
             if (m_k == 2*OH-1) m_phase = 2;
             else m_k++;
           end
        default: if (a) begin m_phase = 0; m_k = 0; end
      endcase
    end
    #1;
    check_outputs();
  endtask

  // Start a frame and feed it; returns cycles from the start edge to frame_valid.
  task automatic run_frame(input bit pattern, input int stall_at, input int stall_len,
                           input int start_pulse_at, output int cycles);
    int acc, st;
    start = 1'b1; in_valid = 1'b1; in_data = rnd_data();  // idle data must be ignored
    tick();
    start = 1'b0;
    acc = 0; st = 0; cycles = 0;
    while (frame_valid !== 1'b1 && cycles < 400) begin
      start = (cycles == start_pulse_at);
      if (acc == stall_at && st < stall_len) begin
        in_valid = 1'b0; st++;
      end else begin
        in_valid = 1'b1;
      end
      in_data = pattern ? pat_data(acc) : rnd_data();
      tick();
      if (in_valid) acc++;
      cycles++;
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  // Linger one cycle in DONE with junk input, then acknowledge.
  task automatic finish_frame(input bit pulse_start);
    start = pulse_start; in_valid = 1'b1; in_data = rnd_data();
    tick();
    start = 1'b0;
    check("fv_held", frame_valid, 1);
    frame_ack = 1'b1; in_data = rnd_data();
    tick();
    frame_ack = 1'b0; in_valid = 1'b0;
    check("fv_cleared", frame_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; frame_ack = 1'b0; in_data = '0;
    model_reset();
    #1;
    check_outputs();
    tick();
    reset = 1'b0;
    // Ignored stimulus while idle and no start.
    in_valid = 1'b1; in_data = rnd_data(); frame_ack = 1'b1;
    tick();
    in_valid = 1'b0; frame_ack = 1'b0;
    tick();

    // Full-rate patterned frame.
    run_frame(1'b1, -1, 0, -1, cyc);
    check("frame_cycles_full", cyc, 2*OH);
    finish_frame(1'b1);

    // Stall for 3 cycles after the accept at row 5, column 0.
    run_frame(1'b0, 11, 3, -1, cyc);
    check("frame_cycles_stall", cyc, 2*OH + 3);
    finish_frame(1'b0);

    // Start pulse mid-collect is ignored.
    run_frame(1'b0, -1, 0, 20, cyc);
    check("frame_cycles_start_ignored", cyc, 2*OH);
    finish_frame(1'b1);

    // Back-to-back frame fully replaces the previous one.
    run_frame(1'b1, -1, 0, -1, cyc);
    check("frame_cycles_b2b", cyc, 2*OH);
    finish_frame(1'b0);

    // Asynchronous reset at row 13, column 1.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 27; i++) begin in_data = rnd_data(); tick(); end
    in_valid = 1'b0;
    check("pre_reset_row", rowNumber, 13);
    check("pre_reset_col", column, 1);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    tick();
    reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin in_data = rnd_data(); tick(); end
    in_valid = 1'b0;

    // Random soak with occasional mid-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      frame_ack = ($urandom_range(0, 3) == 0);
      in_data   = rnd_data();
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    start = 1'b0; in_valid = 1'b0; frame_ack = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
